btn_press_encoder: RTL and testbench

- Input front end for the Genius game. Converts the three raw push buttons into clean, single press events.
- Path per press: synchronise, debounce, require release, encode to a 2-bit code, present on a valid/ack handshake.
- The game FSM is the consumer. It takes one press per ack and compares the code against the sequence value.

---
 rtl/btn_press_encoder.sv | 140 ++++++++++++++
 tb/tb_btn_press_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_encoder.sv
// Button front end for the Genius game: synchronise, debounce, require release, and encode
// the three push buttons into single press events on a valid/ack handshake.
// Optional build macro BTN_ACTIVE_LOW_EN: buttons are active-low (btn=3'b111 means idle).
module btn_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn,
  output logic [1:0] press_code,
  output logic       press_valid,
  input  logic       press_ack,
  output logic       multi_press,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  logic [2:0]                  btn_in;
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  s;
  logic [1:0]                  state, state_next;
  logic [CNT_W-1:0]            cnt, cnt_next;
  logic [2:0]                  cand, cand_next;
  logic                        accept;
  logic                        single;
  logic [1:0]                  cand_code;

`ifdef BTN_ACTIVE_LOW_EN
  assign btn_in = ~btn;
`else
  assign btn_in = btn;
`endif

  // NOTE: reset here is synchronous, so it only appears inside the clocked branch, never in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  assign single    = (cand == 3'b001) || (cand == 3'b010) || (cand == 3'b100);
  assign cand_code = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (s != 3'b000) begin
          cand_next  = s;
          cnt_next   = '0;
          state_next = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (s != cand) begin
          if (s == 3'b000) begin
            state_next = IDLE;
          end else begin
            cand_next = s;
            cnt_next  = '0;
          end
        end else if (cnt == CNT_LAST) begin
          accept     = 1'b1;
          state_next = HELD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        // Extra buttons joining an accepted press are deliberately ignored.
        if (s == 3'b000) begin
          cnt_next   = '0;
          state_next = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (s != 3'b000) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      press_valid <= 1'b0;
      press_code  <= 2'd0;
      multi_press <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      cand        <= cand_next;
      multi_press <= accept && !single;

      // An ack in the same cycle frees the slot, so a new press can load without overrun.
      if (accept && single && (!press_valid || press_ack)) begin
        press_valid <= 1'b1;
        press_code  <= cand_code;
      end else if (press_valid && press_ack) begin
        press_valid <= 1'b0;
      end

      if (press_ack) begin
        overrun <= 1'b0;
      end else if (accept && single && press_valid) begin
        overrun <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_btn_press_encoder.sv
// Self-checking bench for btn_press_encoder (default active-high build); the reference model
// reasons about how long the synchronised button pattern has been stable, not about FSM states.
module tb_btn_press_encoder;

  localparam int DC  = 16;
  localparam int SS  = 2;
  localparam int LAT = SS + DC + 1;

  logic       clock;
  logic       reset;
  logic [2:0] btn;
  logic [1:0] press_code;
  logic       press_valid;
  logic       press_ack;
  logic       multi_press;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;
  int cyc;

  btn_press_encoder #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn         (btn),
    .press_code  (press_code),
    .press_valid (press_valid),
    .press_ack   (press_ack),
    .multi_press (multi_press),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: a press is accepted once a nonzero pattern has been seen unchanged for
  // DC+1 consecutive edges while armed; the model re-arms after DC+1 consecutive idle edges.
  logic [2:0] sq [SS];
  int         nz_run;
  int         z_run;
  bit         armed;
  logic [2:0] run_pat;
  logic       m_valid, m_multi, m_overrun, m_busy;
  logic [1:0] m_code;

  always @(posedge clock) begin
    logic [2:0] s_now;
    logic [2:0] pat;
    bit         acc;
    s_now = sq[SS-1];
    acc   = 1'b0;
    pat   = 3'b000;
    if (!reset) begin
      for (int i = 0; i < SS; i++) sq[i] = 3'b000;
      armed = 1'b1; nz_run = 0; z_run = 0; run_pat = 3'b000;
      m_valid = 1'b0; m_code = 2'd0; m_multi = 1'b0; m_overrun = 1'b0; m_busy = 1'b0;
    end else begin
      if (armed) begin
        if (s_now == 3'b000) nz_run = 0;
        else if (nz_run > 0 && s_now == run_pat) nz_run++;
        else begin run_pat = s_now; nz_run = 1; end
        if (nz_run == DC + 1) begin
          acc = 1'b1; pat = run_pat; armed = 1'b0; nz_run = 0; z_run = 0;
        end
      end else begin
        if (s_now == 3'b000) z_run++;
        else z_run = 0;
        if (z_run == DC + 1) begin armed = 1'b1; z_run = 0; end
      end
      m_multi = acc && ($countones(pat) > 1);
      if (press_ack) m_overrun = 1'b0;
      if (acc && $countones(pat) == 1) begin
        if (!m_valid || press_ack) begin
          m_valid = 1'b1;
          for (int i = 0; i < 3; i++) if (pat[i]) m_code = 2'(i);
        end else begin
          m_overrun = 1'b1;
        end
      end else if (press_ack && m_valid) begin
        m_valid = 1'b0;
      end
      m_busy = !(armed && s_now == 3'b000);
      for (int i = SS - 1; i > 0; i--) sq[i] = sq[i-1];
      sq[0] = btn;
    end
  end

  logic [5:0] obs, exp_vec;
  assign obs     = {press_valid, press_valid ? press_code : 2'b00, multi_press, overrun, busy};
  assign exp_vec = {m_valid, m_valid ? m_code : 2'b00, m_multi, m_overrun, m_busy};

  task automatic test_reset();
    reset = 1'b0; btn = 3'b000; press_ack = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", press_valid); end
    checks++; if (press_code !== 2'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", press_code); end
    checks++; if (multi_press !== 1'b0) begin errors++; $display("FAIL reset_multi got=%b exp=0", multi_press); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_clean_press();
    int t0, rise, rises;
    rise = -1; rises = 0;
    btn = 3'b010; t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
      if (press_valid && rise < 0) rise = cyc - t0;
    end
    checks++;
    if (rise != LAT || press_code !== 2'd1) begin
      errors++; $display("FAIL clean_latency got=%0d code=%0d exp=%0d code=1", rise, press_code, LAT);
    end
    btn = 3'b000; press_ack = 1'b1;
    @(negedge clock);
    press_ack = 1'b0;
    checks++;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL clean_ack got=%b exp=0", press_valid); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL clean_release cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
      if (press_valid) rises++;
    end
    checks++;
    if (rises != 0) begin errors++; $display("FAIL clean_no_second got=%0d exp=0", rises); end
  endtask

  task automatic test_bounce();
    int t0, rise, events;
    rise = -1; events = 0;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 3'b001 : 3'b000;
      repeat (3) begin
        @(negedge clock);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL bounce_toggle cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
        if (press_valid) events++;
      end
    end
    btn = 3'b001; t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL bounce_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
      if (press_valid && rise < 0) begin rise = cyc - t0; events++; end
    end
    checks++;
    if (rise != LAT || press_code !== 2'd0 || events != 1) begin
      errors++; $display("FAIL bounce_event latency=%0d code=%0d events=%0d exp latency=%0d code=0 events=1", rise, press_code, events, LAT);
    end
    btn = 3'b000; press_ack = 1'b1;
    @(negedge clock);
    press_ack = 1'b0;
    repeat (30) @(negedge clock);
  endtask

  task automatic test_multi_press();
    int pulses, valids;
    pulses = 0; valids = 0;
    btn = 3'b101;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL multi_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
      if (multi_press) pulses++;
      if (press_valid) valids++;
    end
    checks++;
    if (pulses != 1 || valids != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL multi_event pulses=%0d valids=%0d busy=%b exp pulses=1 valids=0 busy=1", pulses, valids, busy);
    end
    btn = 3'b000;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL multi_release cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL multi_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    logic [2:0] seq [4];
    seq[0] = 3'b100; seq[1] = 3'b000; seq[2] = 3'b001; seq[3] = 3'b000;
    for (int p = 0; p < 4; p++) begin
      btn = seq[p];
      for (int i = 0; i < 25; i++) begin
        @(negedge clock);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL overrun_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
      end
    end
    checks++;
    if (press_valid !== 1'b1 || press_code !== 2'd2 || overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag valid=%b code=%0d overrun=%b exp valid=1 code=2 overrun=1", press_valid, press_code, overrun);
    end
    press_ack = 1'b1;
    @(negedge clock);
    press_ack = 1'b0;
    checks++;
    if (press_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear valid=%b overrun=%b exp valid=0 overrun=0", press_valid, overrun);
    end
  endtask

  task automatic test_simultaneous();
    int t0;
    btn = 3'b010;
    repeat (25) @(negedge clock);
    btn = 3'b000;
    repeat (25) @(negedge clock);
    checks++;
    if (press_valid !== 1'b1 || press_code !== 2'd1) begin
      errors++; $display("FAIL simul_first valid=%b code=%0d exp valid=1 code=1", press_valid, press_code);
    end
    btn = 3'b001; t0 = cyc;
    while (cyc < t0 + LAT - 1) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL simul_wait cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
    end
    press_ack = 1'b1;
    @(negedge clock);
    press_ack = 1'b0;
    checks++;
    if (press_valid !== 1'b1 || press_code !== 2'd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL simul_load valid=%b code=%0d overrun=%b exp valid=1 code=0 overrun=0", press_valid, press_code, overrun);
    end
    btn = 3'b000; press_ack = 1'b1;
    @(negedge clock);
    press_ack = 1'b0;
    repeat (25) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int t1, rise;
    rise = -1;
    btn = 3'b100;
    repeat (LAT + 3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1; t1 = cyc;
    checks++;
    if ({press_valid, press_code, multi_press, overrun, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_mid got=%b exp=000000", {press_valid, press_code, multi_press, overrun, busy});
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL reset_mid_run cyc=%0d got=%b exp=%b", cyc, obs, exp_vec); end
      if (press_valid && rise < 0) rise = cyc - t1;
    end
    checks++;
    if (rise != LAT || press_code !== 2'd2) begin
      errors++; $display("FAIL reset_mid_latency got=%0d code=%0d exp=%0d code=2", rise, press_code, LAT);
    end
    btn = 3'b000; press_ack = 1'b1;
    @(negedge clock);
    press_ack = 1'b0;
    repeat (25) @(negedge clock);
  endtask

  task automatic test_random();
    logic [2:0] wave [$];
    logic [2:0] pat;
    int         hold;
    for (int it = 0; it < 30; it++) begin
      wave.delete();
      if ($urandom_range(0, 3) != 0) pat = 3'b001 << $urandom_range(0, 2);
      else pat = 3'b011 << $urandom_range(0, 1) | (($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
          repeat ($urandom_range(1, 4)) wave.push_back(pat);
          repeat ($urandom_range(1, 4)) wave.push_back(3'b000);
        end
      end
      hold = $urandom_range(5, 40);
      for (int h = 0; h < hold; h++) begin
        wave.push_back((h > 22 && $urandom_range(0, 2) == 0) ? (pat | 3'(1 << $urandom_range(0, 2))) : pat);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) wave.push_back(3'b000);
        repeat ($urandom_range(1, 3)) wave.push_back(pat);
      end
      repeat ($urandom_range(3, 30)) wave.push_back(3'b000);
      foreach (wave[i]) begin
        btn = wave[i];
        press_ack = ($urandom_range(0, 3) == 0);
        @(negedge clock);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, cyc, obs, exp_vec); end
      end
    end
    btn = 3'b000; press_ack = 1'b0;
    repeat (25) @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_press();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
